value_change_capture: RTL and testbench
=======================================

Name: value_change_capture

Overview:
- Downstream trace stage for the counter/shift-register test design.
- Samples a wide signal (e.g. the 127-bit shift-register output) every enabled cycle and detects value changes.
- Each change is queued as a timestamped record in a small FIFO and drained over a valid/ready interface to the FST record writer.
- Models, in RTL, the change-only dumping the writer library performs in software; used as an integration-test golden source.

Parameters:
- WIDTH, 127, width of monitored signal and of out_value.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- TS_W, 32, timestamp counter width.
- DROP_W, 16, drop counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  sample enable; when low, no sampling and time does not advance.
- sig_in  input  WIDTH  monitored signal.
- out_valid  output  1  head record available.
- out_ready  input  1  consumer accepts head record.
- out_time  output  TS_W  timestamp of head record.
- out_value  output  WIDTH  sampled value of head record.
- out_first  output  1  head record is the initial snapshot after reset.
- overflow  output  1  sticky; set when a record was dropped.
- drop_count  output  DROP_W  number of dropped records, saturating.

Behaviour:
- Reset (async assert, sync-safe deassert) clears the following:
  - timestamp = 0, prev = 0, first_pending = 1.
  - FIFO empty: out_valid = 0; out_time, out_value, out_first = 0.
  - overflow = 0, drop_count = 0.
- Timestamp:
  - Increments by 1 on each edge with en = 1.
  - Wraps 2^TS_W-1 -> 0 with no special record.
  - A record carries the timestamp value before the increment at that edge.
- Record condition, evaluated at an edge with en = 1: first_pending = 1, OR sig_in != prev.
- Every en = 1 edge:
  - prev <= sig_in, whether or not the record was queued.
  - first_pending <= 0.
- Record contents: {time, sig_in, first = first_pending}.
- FIFO:
  - Show-ahead, registered storage; head drives out_* directly.
  - out_valid = not empty.
  - Pop on edge with out_valid & out_ready.
- Latency: change sampled at edge N -> out_valid high in the cycle after edge N (1 cycle) when the FIFO was empty.
- Push when record & (not full | pop at same edge). Full with simultaneous pop: push succeeds and count is unchanged.
- Full, record, and no pop:
  - Record dropped; overflow <= 1.
  - drop_count increments, saturating at 2^DROP_W-1.
  - FIFO contents unchanged.
- en = 0: no sampling, no push, timestamp and prev hold; FIFO still drains.
- out_ready while empty: ignored.
- out_* must be stable while out_valid & !out_ready.
- Reset mid-operation: all queued records discarded; the next en edge produces a new first record at time 0.
- Pointers: log2(DEPTH)+1 bits for full/empty disambiguation, with wrap-around.

Test Plan:
- Reset, en=1, sig_in held at 0x5, out_ready=1 -> one record {time 0, value 0x5, first 1}; no further records for 10 cycles.
- sig_in driven by the shift-register pattern (0x3, 0xF, 0x3F, ...), one change per cycle, out_ready=1 -> records at times 0,1,2,... with matching values; out_first only on the first; overflow stays 0.
- out_ready=0, 6 consecutive changes, DEPTH=4 -> 4 records queued (times 0..3) and 2 dropped. Check overflow=1 and drop_count=2. Raise out_ready -> exactly times 0,1,2,3 drained in order, with out_* stable while stalled.
- Full FIFO, change arriving on the same edge as a pop -> no drop, drop_count unchanged, new record appears last.
- en toggled 1,0,0,1 with sig_in changing during en=0 -> no records while en=0. Timestamp held, so the record after re-enable carries time 1 and the value at re-enable.
- Assert rst for 1 cycle with 3 records queued -> out_valid=0 immediately (async), overflow cleared. Next en edge gives {time 0, first 1}.

Source files
------------

// File: rtl/value_change_capture.sv
// Change-only trace capture: samples a wide signal on enabled cycles and queues
// timestamped records of every value change in a small show-ahead FIFO.
module value_change_capture #(
    parameter int WIDTH  = 127,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 32,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  sig_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TS_W-1:0]   out_time,
    output logic [WIDTH-1:0]  out_value,
    output logic              out_first,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [TS_W-1:0]   ts_r;
    logic [WIDTH-1:0]  prev_r;
    logic              first_pending_r;
    logic [TS_W-1:0]   mem_time_r  [DEPTH];
    logic [WIDTH-1:0]  mem_value_r [DEPTH];
    logic              mem_first_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic              overflow_r;
    logic [DROP_W-1:0] drop_count_r;

    logic              empty_s;
    logic              full_s;
    logic              record_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;

    // FIFO status and push/pop/drop decisions for the current edge
    always_comb begin
        empty_s  = 1'b0;
        full_s   = 1'b0;
        record_s = 1'b0;
        pop_s    = 1'b0;
        push_s   = 1'b0;
        drop_s   = 1'b0;
        empty_s  = (wr_ptr_r == rd_ptr_r);
        full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        record_s = en && (first_pending_r || (sig_in != prev_r));
        pop_s    = !empty_s && out_ready;
        // A pop on the same edge frees the slot a full FIFO would otherwise lack
        push_s   = record_s && (!full_s || pop_s);
        drop_s   = record_s && full_s && !pop_s;
    end

    // Sampling state: timestamp, previous value and initial-snapshot flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_r            <= {TS_W{1'b0}};
            prev_r          <= {WIDTH{1'b0}};
            first_pending_r <= 1'b1;
        end else if (en) begin
            ts_r            <= ts_r + TS_W'(1);
            prev_r          <= sig_in;
            first_pending_r <= 1'b0;
        end else begin
            ts_r            <= ts_r;
            prev_r          <= prev_r;
            first_pending_r <= first_pending_r;
        end
    end

    // Record storage and read/write pointers; cleared so the head reads zero after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_time_r[i]  <= {TS_W{1'b0}};
                mem_value_r[i] <= {WIDTH{1'b0}};
                mem_first_r[i] <= 1'b0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                mem_time_r[wr_ptr_r[AW-1:0]]  <= ts_r;
                mem_value_r[wr_ptr_r[AW-1:0]] <= sig_in;
                mem_first_r[wr_ptr_r[AW-1:0]] <= first_pending_r;
                wr_ptr_r                      <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r   <= 1'b0;
            drop_count_r <= {DROP_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_count_r != {DROP_W{1'b1}}) begin
                drop_count_r <= drop_count_r + DROP_W'(1);
            end else begin
                drop_count_r <= drop_count_r;
            end
        end else begin
            overflow_r   <= overflow_r;
            drop_count_r <= drop_count_r;
        end
    end

    assign out_valid  = !empty_s;
    assign out_time   = mem_time_r[rd_ptr_r[AW-1:0]];
    assign out_value  = mem_value_r[rd_ptr_r[AW-1:0]];
    assign out_first  = mem_first_r[rd_ptr_r[AW-1:0]];
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_value_change_capture.sv
// Directed-vector bench for value_change_capture: one task per scenario,
// each with hand-computed expected records.
module tb_value_change_capture;

    localparam int WIDTH  = 127;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 32;
    localparam int DROP_W = 16;

    logic              clk;
    logic              rst;
    logic              en;
    logic [WIDTH-1:0]  sig_in;
    logic              out_valid;
    logic              out_ready;
    logic [TS_W-1:0]   out_time;
    logic [WIDTH-1:0]  out_value;
    logic              out_first;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    int vec_count;
    int err_count;

    value_change_capture #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_time(out_time),
        .out_value(out_value), .out_first(out_first), .overflow(overflow),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en        = 1'b0;
        out_ready = 1'b0;
        sig_in    = {WIDTH{1'b0}};
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b0; out_ready = 1'b0; sig_in = {WIDTH{1'b0}};
        rst = 1'b1;
        #12;
        vec_count++;
        if (out_valid !== 1'b0 || out_time !== 32'd0 || out_value !== 127'd0 ||
            out_first !== 1'b0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            $display("FAIL reset_state: got v=%b t=%0d val=%0h f=%b ovf=%b drops=%0d want all zero",
                     out_valid, out_time, out_value, out_first, overflow, drop_count);
            err_count++;
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_hold();
        int extra;
        do_reset();
        en = 1'b1; out_ready = 1'b1; sig_in = 127'h5;
        step();
        vec_count++;
        if (out_valid !== 1'b1 || out_time !== 32'd0 || out_value !== 127'h5 || out_first !== 1'b1) begin
            $display("FAIL hold_first: got v=%b t=%0d val=%0h f=%b want v=1 t=0 val=5 f=1",
                     out_valid, out_time, out_value, out_first);
            err_count++;
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid === 1'b1) extra++;
        end
        vec_count++;
        if (extra !== 0) begin
            $display("FAIL hold_no_more: got %0d extra record cycles want 0", extra);
            err_count++;
        end
    endtask

    task automatic test_shift();
        logic [WIDTH-1:0] pat;
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        pat = 127'h3;
        for (int k = 0; k < 6; k++) begin
            sig_in = pat;
            step();
            vec_count++;
            if (out_valid !== 1'b1 || out_time !== TS_W'(k) || out_value !== pat ||
                out_first !== (k == 0)) begin
                $display("FAIL shift_rec%0d: got v=%b t=%0d val=%0h f=%b want v=1 t=%0d val=%0h f=%b",
                         k, out_valid, out_time, out_value, out_first, k, pat, (k == 0));
                err_count++;
            end
            pat = {pat[WIDTH-3:0], 2'b11};
        end
        vec_count++;
        if (overflow !== 1'b0) begin
            $display("FAIL shift_overflow: got %b want 0", overflow);
            err_count++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            sig_in = WIDTH'(k);
            step();
        end
        en = 1'b0;
        vec_count++;
        if (overflow !== 1'b1 || drop_count !== 16'd2) begin
            $display("FAIL ovf_flags: got ovf=%b drops=%0d want ovf=1 drops=2", overflow, drop_count);
            err_count++;
        end
        for (int s = 0; s < 3; s++) begin
            vec_count++;
            if (out_valid !== 1'b1 || out_time !== 32'd0 || out_value !== 127'd1 || out_first !== 1'b1) begin
                $display("FAIL ovf_stall%0d: got v=%b t=%0d val=%0h f=%b want v=1 t=0 val=1 f=1",
                         s, out_valid, out_time, out_value, out_first);
                err_count++;
            end
            step();
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            vec_count++;
            if (out_valid !== 1'b1 || out_time !== TS_W'(k) || out_value !== WIDTH'(k + 1) ||
                out_first !== 1'b0) begin
                $display("FAIL ovf_drain%0d: got v=%b t=%0d val=%0h f=%b want v=1 t=%0d val=%0h f=0",
                         k, out_valid, out_time, out_value, out_first, k, k + 1);
                err_count++;
            end
        end
        step();
        vec_count++;
        if (out_valid !== 1'b0) begin
            $display("FAIL ovf_empty: got v=%b want 0", out_valid);
            err_count++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sig_in = WIDTH'(k);
            step();
        end
        sig_in = 127'h9; out_ready = 1'b1;
        step();
        en = 1'b0;
        vec_count++;
        if (overflow !== 1'b0 || drop_count !== 16'd0 || out_time !== 32'd1) begin
            $display("FAIL b2b_nodrop: got ovf=%b drops=%0d t=%0d want ovf=0 drops=0 t=1",
                     overflow, drop_count, out_time);
            err_count++;
        end
        for (int k = 2; k <= 4; k++) begin
            step();
            vec_count++;
            if (out_valid !== 1'b1 || out_time !== TS_W'(k) ||
                out_value !== ((k == 4) ? 127'h9 : WIDTH'(k + 1))) begin
                $display("FAIL b2b_drain%0d: got v=%b t=%0d val=%0h want t=%0d", k,
                         out_valid, out_time, out_value, k);
                err_count++;
            end
        end
        step();
        vec_count++;
        if (out_valid !== 1'b0) begin
            $display("FAIL b2b_empty: got v=%b want 0", out_valid);
            err_count++;
        end
    endtask

    task automatic test_enable();
        do_reset();
        out_ready = 1'b1; en = 1'b1; sig_in = 127'hA;
        step();
        vec_count++;
        if (out_valid !== 1'b1 || out_time !== 32'd0 || out_value !== 127'hA || out_first !== 1'b1) begin
            $display("FAIL en_first: got v=%b t=%0d val=%0h f=%b want v=1 t=0 val=a f=1",
                     out_valid, out_time, out_value, out_first);
            err_count++;
        end
        en = 1'b0; sig_in = 127'hB;
        step();
        sig_in = 127'hC;
        vec_count++;
        if (out_valid !== 1'b0) begin
            $display("FAIL en_off1: got v=%b want 0", out_valid);
            err_count++;
        end
        step();
        vec_count++;
        if (out_valid !== 1'b0) begin
            $display("FAIL en_off2: got v=%b want 0", out_valid);
            err_count++;
        end
        en = 1'b1; sig_in = 127'hD;
        step();
        en = 1'b0;
        vec_count++;
        if (out_valid !== 1'b1 || out_time !== 32'd1 || out_value !== 127'hD || out_first !== 1'b0) begin
            $display("FAIL en_resume: got v=%b t=%0d val=%0h f=%b want v=1 t=1 val=d f=0",
                     out_valid, out_time, out_value, out_first);
            err_count++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            sig_in = WIDTH'(k);
            step();
        end
        en = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vec_count++;
        if (out_valid !== 1'b1 || overflow !== 1'b1 || out_time !== 32'd1) begin
            $display("FAIL mid_pre: got v=%b ovf=%b t=%0d want v=1 ovf=1 t=1", out_valid, overflow, out_time);
            err_count++;
        end
        rst = 1'b1;
        #1;
        vec_count++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            $display("FAIL mid_async: got v=%b ovf=%b drops=%0d want 0 0 0", out_valid, overflow, drop_count);
            err_count++;
        end
        #3;
        rst = 1'b0; en = 1'b1; sig_in = 127'h77;
        step();
        vec_count++;
        if (out_valid !== 1'b1 || out_time !== 32'd0 || out_value !== 127'h77 || out_first !== 1'b1) begin
            $display("FAIL mid_restart: got v=%b t=%0d val=%0h f=%b want v=1 t=0 val=77 f=1",
                     out_valid, out_time, out_value, out_first);
            err_count++;
        end
    endtask

    initial begin
        vec_count = 0;
        err_count = 0;
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; sig_in = {WIDTH{1'b0}};
        test_reset();
        test_hold();
        test_shift();
        test_overflow();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
